// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - read-domain burst master draining N words from a FIFO onto a valid/ready stream
//
// Purpose:
//   On start_i (accepted only in IDLE) reads exactly len_i good words from the
//   FIFO read port and presents them in order on a valid/ready stream.
//   A 2-entry output buffer absorbs the FIFO's 1-cycle read latency so a sink
//   holding m_ready_i high receives one word per cycle. Reads that return with
//   fifo_rd_error_i set are discarded, retried and counted (saturating).
//
// Ports:
//   clk_i            read-domain clock, posedge
//   rst_i            asynchronous active-high reset
//   start_i, len_i   burst request and length (sampled together in IDLE)
//   busy_o           high in READ and DONE
//   done_o           one-cycle pulse when the burst completes
//   fifo_rd_en_o     FIFO read enable (combinational)
//   fifo_rdata_i     FIFO read data, valid the cycle after fifo_rd_en_o
//   fifo_empty_i     FIFO empty flag
//   fifo_rd_error_i  FIFO underflow flag, aligned with fifo_rdata_i
//   m_valid_o, m_data_o, m_ready_i   output stream
//   err_cnt_o        saturating count of errored reads

module fifo_burst_reader #(
    parameter int WIDTH     = 8,
    parameter int LEN_WIDTH = 8,
    parameter int ERR_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 fifo_rd_en_o,
    input  logic [WIDTH-1:0]     fifo_rdata_i,
    input  logic                 fifo_empty_i,
    input  logic                 fifo_rd_error_i,
    output logic                 m_valid_o,
    output logic [WIDTH-1:0]     m_data_o,
    input  logic                 m_ready_i,
    output logic [ERR_WIDTH-1:0] err_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = '0;
    localparam logic [ERR_WIDTH-1:0] ERR_ONE  = ERR_WIDTH'(1);
    localparam logic [ERR_WIDTH-1:0] ERR_MAX  = '1;

    state_t               state;
    logic [LEN_WIDTH-1:0] remaining;    // good words still to be captured
    logic                 inflight;     // a read was issued last cycle
    logic [1:0]           occ;          // output buffer occupancy, 0..2
    logic [WIDTH-1:0]     buf_head;     // drives m_data_o
    logic [WIDTH-1:0]     buf_tail;

    logic                 start_accept;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic                 drained;
    logic [2:0]           committed;
    logic [LEN_WIDTH-1:0] inflight_ext;

    assign start_accept = (state == ST_IDLE) && start_i;
    assign pop          = m_valid_o && m_ready_i;
    assign push         = inflight && !fifo_rd_error_i;
    assign drop         = inflight && fifo_rd_error_i;
    assign drained      = (remaining == LEN_ZERO) && !inflight && (occ == 2'd0);
    assign inflight_ext = {{(LEN_WIDTH-1){1'b0}}, inflight};

    // Buffer slots already spoken for after this cycle: current contents plus
    // the word on its way back, minus the word leaving now. occ never goes
    // below pop, so the subtraction cannot wrap.
    assign committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    // remaining > inflight keeps the outstanding read from being over-issued:
    // remaining only drops when that read actually lands.
    assign fifo_rd_en_o = (state == ST_READ) && !fifo_empty_i &&
                          (remaining > inflight_ext) && (committed < 3'd2);

    assign m_valid_o = (occ != 2'd0);
    assign m_data_o  = buf_head;

    // Control FSM with registered busy/done.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        busy_o <= 1'b1;
                        if (len_i == LEN_ZERO) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state  <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (drained) begin
                        state  <= ST_DONE;
                        done_o <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

    // Read tracking and error counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            remaining <= '0;
            inflight  <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            inflight <= fifo_rd_en_o;
            if (start_accept) begin
                remaining <= len_i;
            end else if (push) begin
                remaining <= remaining - LEN_ONE;
            end
            // Errored returns leave remaining alone so the word is re-read.
            if (drop && (err_cnt_o != ERR_MAX)) begin
                err_cnt_o <= err_cnt_o + ERR_ONE;
            end
        end
    end

    // Two-entry output buffer, head always at buf_head.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ      <= 2'd0;
            buf_head <= '0;
            buf_tail <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        buf_head <= fifo_rdata_i;
                    end else begin
                        buf_tail <= fifo_rdata_i;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf_head <= buf_tail;
                    occ      <= occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever
                    // remains after the head leaves.
                    if (occ == 2'd1) begin
                        buf_head <= fifo_rdata_i;
                    end else begin
                        buf_head <= buf_tail;
                        buf_tail <= fifo_rdata_i;
                    end
                end
                default: begin
                    occ <= occ;
                end
            endcase
        end
    end

endmodule
